alu_seq: RTL and testbench

- Parametrised WIDTH-bit sequential ALU for the CPU datapath, generalising the 1-bit AND/OR/ADD/XOR slice.
- Adds subtract, signed set-less-than, and status flags, all completing in one cycle.
- Adds two multi-cycle operations: an iterative left shift and an unsigned shift-add multiply.
- Operands are latched on a START/BUSY/DONE handshake, and results are registered.
- Sits between the register file and the writeback mux; the controller stalls while BUSY=1.

---
 rtl/alu_seq.sv | 208 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: WIDTH-bit sequential ALU with a START/BUSY/DONE handshake.
// Single-cycle ops (AND/OR/ADD/XOR/SUB/SLT, and SHL by 0) finish on the
// accepting edge. SHL by k>0 shifts one bit per cycle, and MUL runs one
// shift-add step per cycle. All outputs are registered.
//
// Ports:
//   CLK        rising-edge clock
//   RESET      asynchronous, active-high reset
//   START      request; accepted on a rising edge where BUSY=0
//   OPCODE     operation select, sampled at accept
//   A, B       operands, sampled at accept (SHL amount = B[SHW-1:0])
//   BUSY       high while a multi-cycle operation is in progress
//   DONE       one-cycle pulse when RESULT/flags are updated
//   RESULT     result (low half of the product for MUL)
//   RESULT_HI  high half of the product for MUL, 0 otherwise
//   ZERO       result (MUL: full product) equals zero
//   COUT       carry out for ADD/SUB (SUB: 1 = no borrow)
//   OVERFLOW   signed overflow for ADD/SUB
module alu_seq #(
  parameter int WIDTH = 24,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [2:0]       OPCODE,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic [WIDTH-1:0] RESULT_HI,
  output logic             ZERO,
  output logic             COUT,
  output logic             OVERFLOW
);

  localparam int MSB = WIDTH - 1;
  localparam int CW  = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_XOR = 3'b011,
    OP_SUB = 3'b100,
    OP_SLT = 3'b101,
    OP_SHL = 3'b110,
    OP_MUL = 3'b111
  } op_t;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t           state_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] result_hi_q;
  logic             zero_q;
  logic             cout_q;
  logic             ovf_q;
  logic             mul_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;    // SHL working register / MUL multiplicand
  logic [WIDTH-1:0] b_q;    // MUL multiplier, becomes product low half
  logic [WIDTH-1:0] acc_q;  // MUL product high half

  op_t              op;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_sum;
  logic             add_ovf;
  logic             sub_ovf;
  logic [SHW-1:0]   shamt;
  logic [CW-1:0]    sh_cnt;
  logic [WIDTH-1:0] sc_res;
  logic             sc_cout;
  logic             sc_ovf;
  logic             is_multi;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] a_d;
  logic [WIDTH-1:0] b_d;
  logic [WIDTH-1:0] acc_d;

  assign op = op_t'(OPCODE);

  // Single-cycle datapath on the live inputs; only used on an accepting edge.
  always_comb begin
    add_sum  = {1'b0, A} + {1'b0, B};
    sub_sum  = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
    add_ovf  = (A[MSB] == B[MSB]) & (add_sum[MSB] != A[MSB]);
    sub_ovf  = (A[MSB] != B[MSB]) & (sub_sum[MSB] != A[MSB]);
    shamt    = B[SHW-1:0];
    // Amounts at or beyond WIDTH saturate so the result shifts out to zero.
    sh_cnt   = (int'(shamt) >= WIDTH) ? CW'(WIDTH) : CW'(shamt);
    sc_res   = '0;
    sc_cout  = 1'b0;
    sc_ovf   = 1'b0;
    case (op)
      OP_AND: sc_res = A & B;
      OP_OR:  sc_res = A | B;
      OP_ADD: begin
        sc_res  = add_sum[WIDTH-1:0];
        sc_cout = add_sum[WIDTH];
        sc_ovf  = add_ovf;
      end
      OP_XOR: sc_res = A ^ B;
      OP_SUB: begin
        sc_res  = sub_sum[WIDTH-1:0];
        sc_cout = sub_sum[WIDTH];
        sc_ovf  = sub_ovf;
      end
      OP_SLT: sc_res = {{(WIDTH-1){1'b0}}, sub_sum[MSB] ^ sub_ovf};
      OP_SHL: sc_res = A;  // reaches the outputs only when the amount is 0
      default: sc_res = '0;
    endcase
    is_multi = (op == OP_MUL) | ((op == OP_SHL) & (shamt != '0));
  end

  // One iteration of the multi-cycle ops.
  always_comb begin
    mul_sum = {1'b0, acc_q} + (b_q[0] ? {1'b0, a_q} : '0);
    acc_d   = mul_sum[WIDTH:1];
    b_d     = {mul_sum[0], b_q[WIDTH-1:1]};
    a_d     = {a_q[WIDTH-2:0], 1'b0};
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      mul_q       <= 1'b0;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (START) begin
            if (is_multi) begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
              mul_q   <= (op == OP_MUL);
              a_q     <= A;
              b_q     <= B;
              acc_q   <= '0;
              cnt_q   <= (op == OP_MUL) ? CW'(WIDTH) : sh_cnt;
            end else begin
              done_q      <= 1'b1;
              result_q    <= sc_res;
              result_hi_q <= '0;
              zero_q      <= (sc_res == '0);
              cout_q      <= sc_cout;
              ovf_q       <= sc_ovf;
            end
          end
        end
        S_RUN: begin
          cnt_q <= cnt_q - CW'(1);
          if (mul_q) begin
            b_q   <= b_d;
            acc_q <= acc_d;
          end else begin
            a_q <= a_d;
          end
          // The last step's value goes straight to the outputs, so DONE
          // lands on the same edge as the final iteration.
          if (cnt_q == CW'(1)) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            if (mul_q) begin
              result_q    <= b_d;
              result_hi_q <= acc_d;
              zero_q      <= ({acc_d, b_d} == '0);
            end else begin
              result_q    <= a_d;
              result_hi_q <= '0;
              zero_q      <= (a_d == '0);
            end
          end
        end
      endcase
    end
  end

  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign RESULT    = result_q;
  assign RESULT_HI = result_hi_q;
  assign ZERO      = zero_q;
  assign COUT      = cout_q;
  assign OVERFLOW  = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: table vectors, random vectors checked
// against a behavioural model, and hand sequences for reset, ignored START
// during BUSY, and back-to-back single-cycle ops.
module tb_alu_seq;

  localparam int W = 24;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         START;
  logic [2:0]   OPCODE;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         BUSY;
  logic         DONE;
  logic [W-1:0] RESULT;
  logic [W-1:0] RESULT_HI;
  logic         ZERO;
  logic         COUT;
  logic         OVERFLOW;

  always #5 CLK = ~CLK;

  alu_seq #(.WIDTH(W)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .START     (START),
    .OPCODE    (OPCODE),
    .A         (A),
    .B         (B),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .RESULT    (RESULT),
    .RESULT_HI (RESULT_HI),
    .ZERO      (ZERO),
    .COUT      (COUT),
    .OVERFLOW  (OVERFLOW)
  );

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         z;
    logic         c;
    logic         v;
    int           lat;
    int           acc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  exp_t tbl[15];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] res, input logic [W-1:0] hi,
                              input logic z, input logic c, input logic v, input int lat);
    exp_t e;
    e.op = op; e.a = a; e.b = b; e.res = res; e.hi = hi;
    e.z = z; e.c = c; e.v = v; e.lat = lat; e.acc = 0;
    return e;
  endfunction

  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t          e;
    logic [2*W-1:0] p;
    logic [4:0]    amt5;
    int            amt;
    longint        s;
    longint        smax;
    longint        smin;
    smax = (longint'(1) <<< (W - 1)) - 1;
    smin = -(longint'(1) <<< (W - 1));
    e = mk(op, a, b, '0, '0, 1'b0, 1'b0, 1'b0, 1);
    case (op)
      3'd0: e.res = a & b;
      3'd1: e.res = a | b;
      3'd2: begin
        e.res = a + b;
        e.c   = ((longint'(a) + longint'(b)) >>> W) != 0;
        s     = longint'($signed(a)) + longint'($signed(b));
        e.v   = (s > smax) || (s < smin);
      end
      3'd3: e.res = a ^ b;
      3'd4: begin
        e.res = a - b;
        e.c   = (a >= b);
        s     = longint'($signed(a)) - longint'($signed(b));
        e.v   = (s > smax) || (s < smin);
      end
      3'd5: e.res = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      3'd6: begin
        amt5  = b[4:0];
        amt   = int'(amt5);
        e.res = (amt >= W) ? '0 : (a << amt);
        e.lat = (amt == 0) ? 1 : ((amt >= W) ? W + 1 : amt + 1);
      end
      default: begin
        p     = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        e.res = p[W-1:0];
        e.hi  = p[2*W-1:W];
        e.lat = W + 1;
      end
    endcase
    e.z = (e.res == '0) && (e.hi == '0);
    return e;
  endfunction

  // Scoreboard: every DONE pops the oldest expected op and checks it.
  always @(negedge CLK) begin
    if (!RESET && DONE) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: DONE=1 with no pending op (t=%0t)", $time);
      end else begin
        mon_e = q.pop_front();
        chk("result",    64'(RESULT),    64'(mon_e.res));
        chk("result_hi", 64'(RESULT_HI), 64'(mon_e.hi));
        chk("zero",      64'(ZERO),      64'(mon_e.z));
        chk("cout",      64'(COUT),      64'(mon_e.c));
        chk("overflow",  64'(OVERFLOW),  64'(mon_e.v));
        chk("latency",   64'(cyc - mon_e.acc + 1), 64'(mon_e.lat));
      end
    end
  end

  task automatic issue(input exp_t e);
    @(negedge CLK);
    for (int n = 0; BUSY && n < 300; n++) @(negedge CLK);
    START  = 1'b1;
    OPCODE = e.op;
    A      = e.a;
    B      = e.b;
    e.acc  = cyc + 1;
    q.push_back(e);
  endtask

  // Waits for all pending ops, counting BUSY cycles; pulse_at>=0 raises an
  // ADD request at that cycle, which the DUT must ignore while BUSY.
  task automatic drain(input string nm, input int exp_busy, input int pulse_at);
    int nb;
    int n;
    nb = 0;
    n  = 0;
    @(negedge CLK);
    START = 1'b0;
    #1;
    while (n < 300) begin
      if (BUSY) nb++;
      if (q.size() == 0) break;
      @(negedge CLK);
      START = (n == pulse_at);
      if (n == pulse_at) begin
        OPCODE = 3'd2;
        A      = 24'd7;
        B      = 24'd9;
      end
      #1;
      n++;
    end
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: %0d ops still pending after %0d cycles", nm, q.size(), n);
      q.delete();
    end
    chk({nm, "_busy_cycles"}, 64'(nb), 64'(exp_busy));
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_busy"},      64'(BUSY),      64'(0));
    chk({nm, "_done"},      64'(DONE),      64'(0));
    chk({nm, "_result"},    64'(RESULT),    64'(0));
    chk({nm, "_result_hi"}, 64'(RESULT_HI), 64'(0));
    chk({nm, "_zero"},      64'(ZERO),      64'(0));
    chk({nm, "_cout"},      64'(COUT),      64'(0));
    chk({nm, "_overflow"},  64'(OVERFLOW),  64'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    RESET  = 1'b1;
    START  = 1'b0;
    OPCODE = '0;
    A      = '0;
    B      = '0;

    //       op    A          B          RESULT     HI         Z  C  V  lat
    tbl[0]  = mk(3'd2, 24'h7FFFFF, 24'h000001, 24'h800000, 24'h0,      0, 0, 1, 1);
    tbl[1]  = mk(3'd4, 24'h000005, 24'h000005, 24'h000000, 24'h0,      1, 1, 0, 1);
    tbl[2]  = mk(3'd5, 24'hFFFFFF, 24'h000001, 24'h000001, 24'h0,      0, 0, 0, 1);
    tbl[3]  = mk(3'd6, 24'h000001, 24'd23,     24'h800000, 24'h0,      0, 0, 0, 24);
    tbl[4]  = mk(3'd6, 24'hABCDEF, 24'd0,      24'hABCDEF, 24'h0,      0, 0, 0, 1);
    tbl[5]  = mk(3'd6, 24'h000001, 24'd30,     24'h000000, 24'h0,      1, 0, 0, 25);
    tbl[6]  = mk(3'd2, 24'hFFFFFF, 24'h000001, 24'h000000, 24'h0,      1, 1, 0, 1);
    tbl[7]  = mk(3'd4, 24'h000000, 24'h000001, 24'hFFFFFF, 24'h0,      0, 0, 0, 1);
    tbl[8]  = mk(3'd4, 24'h800000, 24'h000001, 24'h7FFFFF, 24'h0,      0, 1, 1, 1);
    tbl[9]  = mk(3'd5, 24'h000001, 24'hFFFFFF, 24'h000000, 24'h0,      1, 0, 0, 1);
    tbl[10] = mk(3'd5, 24'h800000, 24'h7FFFFF, 24'h000001, 24'h0,      0, 0, 0, 1);
    tbl[11] = mk(3'd7, 24'hFFFFFF, 24'hFFFFFF, 24'h000001, 24'hFFFFFE, 0, 0, 0, 25);
    tbl[12] = mk(3'd7, 24'h000000, 24'h123456, 24'h000000, 24'h0,      1, 0, 0, 25);
    tbl[13] = mk(3'd6, 24'h000003, 24'd5,      24'h000060, 24'h0,      0, 0, 0, 6);
    tbl[14] = mk(3'd2, 24'h800000, 24'h800000, 24'h000000, 24'h0,      1, 1, 1, 1);

    #3;
    chk_all_zero("reset");
    @(negedge CLK);
    RESET = 1'b0;

    foreach (tbl[i]) begin
      issue(tbl[i]);
      drain($sformatf("vec%0d", i), tbl[i].lat - 1, -1);
    end

    // MUL with an ADD request raised mid-run: no extra DONE expected.
    issue(mk(3'd7, 24'h001000, 24'h001000, 24'h000000, 24'h000001, 0, 0, 0, 25));
    drain("mul_ignore_start", 24, 5);

    // Reset during a MUL aborts it: outputs clear at once, no DONE follows.
    issue(model(3'd7, 24'h00ABCD, 24'h000777));
    @(negedge CLK);
    START = 1'b0;
    repeat (8) @(negedge CLK);
    #2;
    RESET = 1'b1;
    #1;
    chk_all_zero("mid_run_reset");
    q.delete();
    @(negedge CLK);
    RESET = 1'b0;
    repeat (30) @(negedge CLK);
    chk("post_reset_busy", 64'(BUSY), 64'(0));
    issue(mk(3'd2, 24'd2, 24'd3, 24'd5, 24'h0, 0, 0, 0, 1));
    drain("post_reset_add", 0, -1);

    // START held across three single-cycle ops: DONE on three consecutive cycles.
    issue(mk(3'd0, 24'hF0F0F0, 24'hFF00FF, 24'hF000F0, 24'h0, 0, 0, 0, 1));
    issue(mk(3'd1, 24'hF0F0F0, 24'hFF00FF, 24'hFFF0FF, 24'h0, 0, 0, 0, 1));
    issue(mk(3'd3, 24'hF0F0F0, 24'hFF00FF, 24'h0FF00F, 24'h0, 0, 0, 0, 1));
    drain("back_to_back", 0, -1);

    // START accepted in the DONE cycle of a RUN completion.
    issue(model(3'd6, 24'h000005, 24'd3));
    @(negedge CLK);
    START = 1'b0;
    for (int n = 0; BUSY && n < 40; n++) @(negedge CLK);
    #1;
    issue(model(3'd3, 24'h123456, 24'h654321));
    drain("start_on_done", 0, -1);

    for (int i = 0; i < 24; i++) begin
      e = model(3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
      issue(e);
      drain($sformatf("rnd%0d", i), e.lat - 1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
